// File: rtl/rv32i_alu.sv
// RV32I execute-stage ALU: combinational result/zero/overflow plus an
// EX/MEM output register holding a copy of all three.
//
// Ports:
//   clk, rst       core clock; synchronous active-high reset of the register
//   a, b           32-bit operands (rs1/PC, rs2/immediate)
//   alu_control    4-bit operation select
//   result, zero, overflow           combinational outputs
//   result_q, zero_q, overflow_q     registered outputs (1-cycle latency)
module rv32i_alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  alu_control,
    output logic [31:0] result,
    output logic        zero,
    output logic        overflow,
    output logic [31:0] result_q,
    output logic        zero_q,
    output logic        overflow_q
);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_SLL   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SRA   = 4'b0111;
    localparam logic [3:0] OP_SLT   = 4'b1000;
    localparam logic [3:0] OP_SLTU  = 4'b1001;
    localparam logic [3:0] OP_PASSB = 4'b1010;

    logic [31:0] sum;
    logic [31:0] diff;
    logic [4:0]  shamt;
    logic        lt_signed;
    logic        lt_unsigned;
    logic        add_ovf;
    logic        sub_ovf;

    assign sum         = a + b;
    assign diff        = a - b;
    // Only the low five bits select a shift; the rest of b is ignored.
    assign shamt       = b[4:0];
    assign lt_signed   = $signed(a) < $signed(b);
    assign lt_unsigned = a < b;

    // Signed overflow: operand signs agree (ADD) or differ (SUB) and the
    // result's sign differs from a.
    assign add_ovf = (a[31] == b[31]) && (sum[31] != a[31]);
    assign sub_ovf = (a[31] != b[31]) && (diff[31] != a[31]);

    always_comb begin
        result   = 32'd0;
        overflow = 1'b0;
        case (alu_control)
            OP_AND:   result = a & b;
            OP_OR:    result = a | b;
            OP_ADD: begin
                result   = sum;
                overflow = add_ovf;
            end
            OP_XOR:   result = a ^ b;
            OP_SLL:   result = a << shamt;
            OP_SRL:   result = a >> shamt;
            OP_SUB: begin
                result   = diff;
                overflow = sub_ovf;
            end
            OP_SRA:   result = $unsigned($signed(a) >>> shamt);
            OP_SLT:   result = {31'd0, lt_signed};
            OP_SLTU:  result = {31'd0, lt_unsigned};
            OP_PASSB: result = b;
            default:  result = 32'd0;
        endcase
    end

    assign zero = (result == 32'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q   <= 32'd0;
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            result_q   <= result;
            zero_q     <= zero;
            overflow_q <= overflow;
        end
    end

endmodule

// File: tb/tb_rv32i_alu.sv
// Directed testbench for rv32i_alu: combinational ops, overflow,
// shifts, compares, undefined codes and the output register.
module tb_rv32i_alu;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  alu_control;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic [31:0] result_q;
    logic        zero_q;
    logic        overflow_q;

    int n_chk;
    int n_pass;

    rv32i_alu dut (
        .clk         (clk),
        .rst         (rst),
        .a           (a),
        .b           (b),
        .alu_control (alu_control),
        .result      (result),
        .zero        (zero),
        .overflow    (overflow),
        .result_q    (result_q),
        .zero_q      (zero_q),
        .overflow_q  (overflow_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic apply(input logic [3:0] op, input logic [31:0] va,
                         input logic [31:0] vb);
        alu_control = op;
        a           = va;
        b           = vb;
        #1;
    endtask

    task automatic comb(input string tag, input logic [3:0] op,
                        input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] er, input logic ez,
                        input logic eo);
        apply(op, va, vb);
        check({tag, ".result"}, result, er);
        check({tag, ".zero"}, {31'd0, zero}, {31'd0, ez});
        check({tag, ".ovf"}, {31'd0, overflow}, {31'd0, eo});
    endtask

    task automatic reg_chk(input string tag, input logic [31:0] er,
                           input logic ez, input logic eo);
        check({tag, ".result_q"}, result_q, er);
        check({tag, ".zero_q"}, {31'd0, zero_q}, {31'd0, ez});
        check({tag, ".ovf_q"}, {31'd0, overflow_q}, {31'd0, eo});
    endtask

    initial begin
        n_chk       = 0;
        n_pass      = 0;
        rst         = 1'b1;
        a           = 32'd0;
        b           = 32'd0;
        alu_control = 4'b0000;
        #2;

        // Basic ops, a=10 b=5
        comb("add", 4'b0010, 32'd10, 32'd5, 32'h0000000F, 1'b0, 1'b0);
        comb("sub", 4'b0110, 32'd10, 32'd5, 32'h00000005, 1'b0, 1'b0);
        comb("and", 4'b0000, 32'd10, 32'd5, 32'h00000000, 1'b1, 1'b0);
        comb("or",  4'b0001, 32'd10, 32'd5, 32'h0000000F, 1'b0, 1'b0);

        // Overflow
        comb("add_ovf", 4'b0010, 32'h7FFFFFFF, 32'h1,
             32'h80000000, 1'b0, 1'b1);
        comb("sub_ovf", 4'b0110, 32'h80000000, 32'h1,
             32'h7FFFFFFF, 1'b0, 1'b1);
        comb("sub_eq", 4'b0110, 32'd5, 32'd5, 32'h0, 1'b1, 1'b0);
        comb("sub_ovf2", 4'b0110, 32'h7FFFFFFF, 32'hFFFFFFFF,
             32'h80000000, 1'b0, 1'b1);
        comb("add_ovf_neg", 4'b0010, 32'h80000000, 32'h80000000,
             32'h0, 1'b1, 1'b1);
        comb("add_neg_ok", 4'b0010, 32'hFFFFFFFF, 32'hFFFFFFFF,
             32'hFFFFFFFE, 1'b0, 1'b0);
        comb("xor_noovf", 4'b0011, 32'h7FFFFFFF, 32'h1,
             32'h7FFFFFFE, 1'b0, 1'b0);

        // Shifts
        comb("sll", 4'b0100, 32'h80000010, 32'd4,
             32'h00000100, 1'b0, 1'b0);
        comb("srl", 4'b0101, 32'h80000010, 32'd4,
             32'h08000001, 1'b0, 1'b0);
        comb("sra", 4'b0111, 32'h80000010, 32'd4,
             32'hF8000001, 1'b0, 1'b0);
        comb("srl_mask", 4'b0101, 32'h80000010, 32'h24,
             32'h08000001, 1'b0, 1'b0);
        comb("sra_31", 4'b0111, 32'h80000000, 32'd31,
             32'hFFFFFFFF, 1'b0, 1'b0);
        comb("sll_mask", 4'b0100, 32'h1, 32'hFFFFFFE1,
             32'h00000002, 1'b0, 1'b0);

        // Compares and misc, a=-1 b=1
        comb("slt", 4'b1000, 32'hFFFFFFFF, 32'h1, 32'h1, 1'b0, 1'b0);
        comb("sltu", 4'b1001, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b1, 1'b0);
        comb("sltu_t", 4'b1001, 32'h1, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0);
        comb("slt_f", 4'b1000, 32'h1, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0);
        comb("xor", 4'b0011, 32'hFFFFFFFF, 32'h1,
             32'hFFFFFFFE, 1'b0, 1'b0);
        comb("passb", 4'b1010, 32'hFFFFFFFF, 32'h1,
             32'h00000001, 1'b0, 1'b0);
        comb("undef_f", 4'b1111, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b1, 1'b0);
        for (int op = 11; op < 15; op++) begin
            comb("undef", op[3:0], 32'h7FFFFFFF, 32'h1, 32'h0, 1'b1, 1'b0);
        end

        // Register: hold reset for two edges
        @(negedge clk);
        rst = 1'b1;
        apply(4'b0010, 32'h7FFFFFFF, 32'h1);
        repeat (2) @(posedge clk);
        #1;
        reg_chk("rst_hold", 32'h0, 1'b0, 1'b0);

        // Release and capture ADD 10+5
        @(negedge clk);
        rst = 1'b0;
        apply(4'b0010, 32'd10, 32'd5);
        @(posedge clk);
        #1;
        reg_chk("cap_add", 32'h0000000F, 1'b0, 1'b0);

        // Capture a zero result
        @(negedge clk);
        apply(4'b0000, 32'd10, 32'd5);
        @(posedge clk);
        #1;
        reg_chk("cap_and", 32'h0, 1'b1, 1'b0);

        // Capture an overflow
        @(negedge clk);
        apply(4'b0010, 32'h7FFFFFFF, 32'h1);
        @(posedge clk);
        #1;
        reg_chk("cap_ovf", 32'h80000000, 1'b0, 1'b1);

        // Mid-stream reset clears register, comb path unaffected
        @(negedge clk);
        apply(4'b0010, 32'd10, 32'd5);
        @(posedge clk);
        #1;
        reg_chk("pre_rst", 32'h0000000F, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        reg_chk("mid_rst", 32'h0, 1'b0, 1'b0);
        check("mid_rst.result", result, 32'h0000000F);
        check("mid_rst.zero", {31'd0, zero}, 32'd0);

        // First capture after release
        @(negedge clk);
        rst = 1'b0;
        apply(4'b0110, 32'd10, 32'd5);
        @(posedge clk);
        #1;
        reg_chk("post_rel", 32'h00000005, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rv32i_alu.md
# rv32i_alu

Integer arithmetic/logic unit for the RV32I core's execute stage. It computes a 32-bit result and a zero flag combinationally from two operands and a 4-bit operation code; the branch unit uses the zero flag. It also holds a registered copy of the result and the flags in a pipeline output register, clocked by the core clock, for the EX/MEM boundary.

## Interface
- No parameters; datapath width is fixed at 32 bits.
- clk  input  1  core clock; the output register updates on the rising edge.
- rst  input  1  synchronous, active-high reset; acts on the rising edge of clk.
- a  input  32  operand A (rs1 or PC).
- b  input  32  operand B (rs2 or immediate).
- alu_control  input  4  operation select.
- result  output  32  combinational result.
- zero  output  1  combinational; 1 when result == 0.
- overflow  output  1  combinational; signed overflow for ADD/SUB, 0 for all other ops.
- result_q  output  32  registered result.
- zero_q  output  1  registered zero.
- overflow_q  output  1  registered overflow.

## Operation
- Encodings of alu_control:
  - 0000 AND: a & b.
  - 0001 OR: a | b.
  - 0010 ADD: a + b, mod 2^32.
  - 0011 XOR: a ^ b.
  - 0100 SLL: a << b[4:0].
  - 0101 SRL: a >> b[4:0], zero-fill.
  - 0110 SUB: a - b, mod 2^32.
  - 0111 SRA: a >>> b[4:0], sign-fill.
  - 1000 SLT: result is 1 if signed a < signed b, else 0.
  - 1001 SLTU: result is 1 if unsigned a < unsigned b, else 0.
  - 1010 PASSB: result = b (for LUI).
  - 1011–1111: result = 0, and therefore zero = 1.
- Shift amounts use only b[4:0]; b[31:5] is ignored.
- Overflow:
  - ADD: overflow = (a[31] == b[31]) && (result[31] != a[31]).
  - SUB: overflow = (a[31] != b[31]) && (result[31] != a[31]).
- No carry-out or exception output. Wraparound is silent.
- SLT/SLTU results are zero-extended to 32 bits.

## Timing
- result, zero and overflow are purely combinational: zero latency, no dependence on clk or rst.
- Register update on every rising edge of clk:
  - rst = 1: result_q = 0, zero_q = 0, overflow_q = 0.
  - rst = 0: result_q, zero_q and overflow_q capture the current result, zero and overflow.
- Registered-output latency is 1 cycle. There is no enable and no stall.
- A reset asserted mid-operation clears the register on that edge. The combinational outputs are unaffected.
- The first capture after reset is released happens on the first edge where rst = 0.
- Outputs are undefined only while an input is X. No internal state exists beyond the output register.

## Test plan
- Basic ops with a=10, b=5, each applied and checked after settling:
  - ADD (0010) -> result 0x0000000F, zero 0.
  - SUB (0110) -> 0x00000005, zero 0.
  - AND (0000) -> 0x00000000, zero 1.
  - OR (0001) -> 0x0000000F, zero 0.
- Overflow:
  - ADD with a=0x7FFFFFFF, b=1 -> result 0x80000000, overflow 1.
  - SUB with a=0x80000000, b=1 -> 0x7FFFFFFF, overflow 1.
  - SUB with a=5, b=5 -> 0, zero 1, overflow 0.
- Shifts with a=0x80000010:
  - SLL, b=4 -> 0x00000100.
  - SRL, b=4 -> 0x08000001.
  - SRA, b=4 -> 0xF8000001.
  - SRL, b=0x24 -> uses shamt 4, result 0x08000001.
- Compares with a=0xFFFFFFFF, b=1:
  - SLT -> 1.
  - SLTU -> 0.
  - XOR -> 0xFFFFFFFE.
  - PASSB -> 0x00000001.
  - Undefined code 1111 -> result 0, zero 1.
- Register:
  - Hold rst=1 for 2 edges -> result_q 0, zero_q 0, overflow_q 0.
  - Release rst, apply ADD with a=10, b=5 -> result_q 0x0000000F one edge later.
  - Assert rst mid-stream -> register is 0 after that edge while result still shows 0x0000000F.
